// File: rtl/arb_rr_4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: FSM state encoding
// and requester count, imported by the RTL and by the bench.
package arb_rr_4_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_e;

endpackage

// File: rtl/arb_rr_4_if.sv
// Request/grant bundle between the requesting units and the arbiter.
// The arbiter is the master; the requesters and the resource form the slave side.
interface arb_rr_4_if;
  import arb_rr_4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [1:0]         sel;
  logic               enable;
  logic [NUM_REQ-1:0] gnt;
  logic               busy;
  logic               timeout;

  modport master (
    input  req, done,
    output sel, enable, gnt, busy, timeout
  );

  modport slave (
    output req, done,
    input  sel, enable, gnt, busy, timeout
  );

endinterface

// File: rtl/arb_rr_4_demux.sv
// One-hot enable decoder: routes a single enable to one of four outputs by sel.
module demux_1_to_4 (
  input  logic [1:0] sel_i,
  input  logic       enable_i,
  output logic       en_1_o,
  output logic       en_2_o,
  output logic       en_3_o,
  output logic       en_4_o
);

  assign en_1_o = enable_i && (sel_i == 2'd0);
  assign en_2_o = enable_i && (sel_i == 2'd1);
  assign en_3_o = enable_i && (sel_i == 2'd2);
  assign en_4_o = enable_i && (sel_i == 2'd3);

endmodule

// File: rtl/arb_rr_4.sv
// Round-robin arbiter for four requesters: grants one at a time, holds until
// done/withdrawal/hold limit, then inserts one dead cycle before re-arbitrating.
module arb_rr_4
  import arb_rr_4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  arb_rr_4_if.master  bus_io
);

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         last_q, last_d;
  logic [NUM_REQ-1:0] gnt;
  logic               holdLimit;
  logic               release_c;

  // Rotate so bit 0 is the requester after last, take the lowest set bit,
  // then undo the rotation; the 2-bit add wraps modulo 4.
  function automatic logic [1:0] rrPick(input logic [NUM_REQ-1:0] reqV,
                                        input logic [1:0]         lastV);
    logic [1:0]           off;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [1:0]           idx;
    off = lastV + 2'd1;
    dbl = {reqV, reqV} >> off;
    rot = dbl[NUM_REQ-1:0];
    idx = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = 2'(i);
    end
    return idx + off;
  endfunction

  assign holdLimit = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign release_c = bus_io.done || !bus_io.req[sel_q] || holdLimit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 2'b00;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      last_q    <= 2'b11;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    enable_d  = enable_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (|bus_io.req) begin
          sel_d    = rrPick(bus_io.req, last_q);
          enable_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (release_c) begin
          enable_d  = 1'b0;
          busy_d    = 1'b0;
          last_d    = sel_q;
          state_d   = TURN;
          // Only a pure hold-limit release flags a timeout; done or withdrawal win.
          timeout_d = !bus_io.done && bus_io.req[sel_q];
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  demux_1_to_4 u_demux (
    .sel_i    (sel_q),
    .enable_i (enable_q),
    .en_1_o   (gnt[0]),
    .en_2_o   (gnt[1]),
    .en_3_o   (gnt[2]),
    .en_4_o   (gnt[3])
  );

  assign bus_io.sel     = sel_q;
  assign bus_io.enable  = enable_q;
  assign bus_io.busy    = busy_q;
  assign bus_io.timeout = timeout_q;
  assign bus_io.gnt     = gnt;

endmodule
